// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate in program order, accept writebacks by tag out of order,
// and retire the head entry onto the reg_file write port once its result is present.
module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic              alloc_has_rd,
  input  logic [4:0]        alloc_rd,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [4:0]        commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic              commit_RegWrite,
  output logic              empty,
  output logic [TAG_W:0]    count
);

  localparam logic [TAG_W:0] PTR_ONE  = {{TAG_W{1'b0}}, 1'b1};
  localparam logic [TAG_W:0] PTR_ZERO = {(TAG_W+1){1'b0}};
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_done;
  logic [DEPTH-1:0]  r_has_rd;
  logic [4:0]        r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [TAG_W:0]    r_head;
  logic [TAG_W:0]    r_tail;

  logic [TAG_W-1:0]  w_head_idx;
  logic [TAG_W-1:0]  w_tail_idx;
  logic [TAG_W:0]    w_count;
  logic              w_full;
  logic              w_alloc;
  logic              w_wb;
  logic              w_commit;

  assign w_head_idx  = r_head[TAG_W-1:0];
  assign w_tail_idx  = r_tail[TAG_W-1:0];
  assign w_count     = r_tail - r_head;
  assign w_full      = (w_count == FULL_CNT);
  assign w_alloc     = alloc_valid && !w_full;
  // A pending writeback and the retiring entry can never coincide: commit needs done, writeback needs !done.
  assign w_wb        = wb_valid && r_valid[wb_tag] && !r_done[wb_tag];
  assign w_commit    = r_valid[w_head_idx] && r_done[w_head_idx] && !flush;

  assign alloc_ready = !w_full;
  assign alloc_tag   = w_tail_idx;
  assign empty       = (w_count == PTR_ZERO);
  assign count       = w_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= {DEPTH{1'b0}};
      r_done  <= {DEPTH{1'b0}};
      r_head  <= PTR_ZERO;
      r_tail  <= PTR_ZERO;
    end else if (flush) begin
      r_valid <= {DEPTH{1'b0}};
      r_done  <= {DEPTH{1'b0}};
      r_head  <= PTR_ZERO;
      r_tail  <= PTR_ZERO;
    end else begin
      if (w_commit) begin
        r_valid[w_head_idx] <= 1'b0;
        r_done[w_head_idx]  <= 1'b0;
        r_head              <= r_head + PTR_ONE;
      end
      if (w_wb) begin
        r_done[wb_tag] <= 1'b1;
      end
      // Placed last so a same-index allocation overrides a writeback in the same cycle.
      if (w_alloc) begin
        r_valid[w_tail_idx] <= 1'b1;
        r_done[w_tail_idx]  <= 1'b0;
        r_tail              <= r_tail + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      if (w_wb) begin
        r_data[wb_tag] <= wb_data;
      end
      if (w_alloc) begin
        r_has_rd[w_tail_idx] <= alloc_has_rd;
        r_rd[w_tail_idx]     <= alloc_rd;
      end
    end
  end

  always_comb begin
    commit_valid    = w_commit;
    commit_tag      = {TAG_W{1'b0}};
    commit_rd       = 5'd0;
    commit_data     = {DATA_W{1'b0}};
    commit_RegWrite = 1'b0;
    if (w_commit) begin
      commit_tag      = w_head_idx;
      commit_rd       = r_rd[w_head_idx];
      commit_data     = r_data[w_head_idx];
      commit_RegWrite = r_has_rd[w_head_idx] && (r_rd[w_head_idx] != 5'd0);
    end else begin
      commit_tag      = {TAG_W{1'b0}};
      commit_rd       = 5'd0;
      commit_data     = {DATA_W{1'b0}};
      commit_RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: expected commits are queued at issue time and
// checked by a negedge monitor; cycle-exact behaviour is checked inline.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid, alloc_has_rd;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        wb_valid;
  logic [2:0]  wb_tag;
  logic [31:0] wb_data;
  logic        flush;
  logic        commit_valid;
  logic [2:0]  commit_tag;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic        commit_RegWrite;
  logic        empty;
  logic [3:0]  count;

  typedef struct packed {
    logic [2:0]  tag;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rw;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t mon_a;
  int   n_chk  = 0;
  int   n_fail = 0;

  reorder_buffer #(.DEPTH(8), .TAG_W(3), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_has_rd(alloc_has_rd), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .flush(flush),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_RegWrite(commit_RegWrite),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every presented commit must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && commit_valid) begin
      n_chk++;
      mon_a = {commit_tag, commit_rd, commit_data, commit_RegWrite};
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_commit: got tag=%0d rd=%0d data=%h rw=%0b, required no commit",
                 commit_tag, commit_rd, commit_data, commit_RegWrite);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_a !== mon_e) begin
          n_fail++;
          $display("FAIL commit_payload: got tag=%0d rd=%0d data=%h rw=%0b, required tag=%0d rd=%0d data=%h rw=%0b",
                   mon_a.tag, mon_a.rd, mon_a.data, mon_a.rw, mon_e.tag, mon_e.rd, mon_e.data, mon_e.rw);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    alloc_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic alloc_one(input logic has_rd, input logic [4:0] rd, input logic [2:0] exp_tag);
    alloc_valid = 1'b1; alloc_has_rd = has_rd; alloc_rd = rd;
    #1 chk("alloc_tag", 64'(alloc_tag), 64'(exp_tag));
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic wb_one(input logic [2:0] tag, input logic [31:0] data);
    wb_valid = 1'b1; wb_tag = tag; wb_data = data;
    step();
    wb_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; alloc_valid = 1'b0; alloc_has_rd = 1'b0; alloc_rd = 5'd0;
    wb_valid = 1'b0; wb_tag = 3'd0; wb_data = 32'd0; flush = 1'b0;
    step();
    step();
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_alloc_tag", 64'(alloc_tag), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    reset = 1'b0;
    step();

    // Test 1: asynchronous reset with 3 live entries, none done
    alloc_one(1'b1, 5'd1, 3'd0);
    alloc_one(1'b1, 5'd2, 3'd1);
    alloc_one(1'b1, 5'd3, 3'd2);
    chk("t1_count_live", 64'(count), 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("t1_empty", 64'(empty), 64'd1);
    chk("t1_count", 64'(count), 64'd0);
    chk("t1_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("t1_regwrite", 64'(commit_RegWrite), 64'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) wb_one(3'(i), 32'h1111_0000 + 32'(i));
    step();
    chk("t1_count_after", 64'(count), 64'd0);

    // Test 2: single alloc, writeback, commit
    do_reset();
    sb_q.push_back('{tag: 3'd0, rd: 5'd5, data: 32'hDEAD_BEEF, rw: 1'b1});
    alloc_one(1'b1, 5'd5, 3'd0);
    chk("t2_no_commit_before_wb", 64'(commit_valid), 64'd0);
    wb_one(3'd0, 32'hDEAD_BEEF);
    #1;
    chk("t2_commit_valid", 64'(commit_valid), 64'd1);
    chk("t2_commit_rd", 64'(commit_rd), 64'd5);
    chk("t2_commit_data", 64'(commit_data), 64'hDEAD_BEEF);
    chk("t2_regwrite", 64'(commit_RegWrite), 64'd1);
    step();
    chk("t2_count_after", 64'(count), 64'd0);

    // Test 3: out-of-order writeback, in-order retirement
    do_reset();
    sb_q.push_back('{tag: 3'd0, rd: 5'd1, data: 32'hA000_0000, rw: 1'b1});
    sb_q.push_back('{tag: 3'd1, rd: 5'd2, data: 32'hA000_0001, rw: 1'b1});
    sb_q.push_back('{tag: 3'd2, rd: 5'd3, data: 32'hA000_0002, rw: 1'b1});
    alloc_one(1'b1, 5'd1, 3'd0);
    alloc_one(1'b1, 5'd2, 3'd1);
    alloc_one(1'b1, 5'd3, 3'd2);
    wb_one(3'd2, 32'hA000_0002);
    #1 chk("t3_tag2_waits", 64'(commit_valid), 64'd0);
    wb_one(3'd0, 32'hA000_0000);
    #1 chk("t3_c0_valid", 64'(commit_valid), 64'd1);
    chk("t3_c0_tag", 64'(commit_tag), 64'd0);
    wb_one(3'd1, 32'hA000_0001);
    #1 chk("t3_c1_tag", 64'(commit_tag), 64'd1);
    chk("t3_count_mid", 64'(count), 64'd2);
    step();
    chk("t3_c2_tag", 64'(commit_tag), 64'd2);
    step();
    chk("t3_empty", 64'(empty), 64'd1);

    // Test 4: fill, extra alloc ignored, commit frees one slot, tail wraps
    do_reset();
    alloc_valid = 1'b1; alloc_has_rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      alloc_rd = 5'(8 + i);
      #1 chk("t4_fill_tag", 64'(alloc_tag), 64'(i));
      step();
    end
    chk("t4_full_count", 64'(count), 64'd8);
    chk("t4_full_ready", 64'(alloc_ready), 64'd0);
    alloc_rd = 5'd20;
    step();
    chk("t4_extra_ignored", 64'(count), 64'd8);
    sb_q.push_back('{tag: 3'd0, rd: 5'd8, data: 32'h4444_0000, rw: 1'b1});
    wb_one(3'd0, 32'h4444_0000);
    #1 chk("t4_commit_valid", 64'(commit_valid), 64'd1);
    chk("t4_ready_during_commit", 64'(alloc_ready), 64'd0);
    step();
    chk("t4_count_after_commit", 64'(count), 64'd7);
    chk("t4_ready_after_commit", 64'(alloc_ready), 64'd1);
    chk("t4_wrap_tag", 64'(alloc_tag), 64'd0);
    step();
    alloc_valid = 1'b0;
    #1 chk("t4_count_refill", 64'(count), 64'd8);
    chk("t4_ready_refill", 64'(alloc_ready), 64'd0);
    chk("t4_tag_after_wrap", 64'(alloc_tag), 64'd1);

    // Test 5: rd=0 and has_rd=0 retire without reg_file write
    do_reset();
    sb_q.push_back('{tag: 3'd0, rd: 5'd0, data: 32'h5555_0000, rw: 1'b0});
    sb_q.push_back('{tag: 3'd1, rd: 5'd7, data: 32'h5555_0001, rw: 1'b0});
    alloc_one(1'b1, 5'd0, 3'd0);
    alloc_one(1'b0, 5'd7, 3'd1);
    wb_one(3'd0, 32'h5555_0000);
    #1 chk("t5_c0_valid", 64'(commit_valid), 64'd1);
    chk("t5_c0_regwrite", 64'(commit_RegWrite), 64'd0);
    wb_one(3'd1, 32'h5555_0001);
    #1 chk("t5_count_dec", 64'(count), 64'd1);
    chk("t5_c1_regwrite", 64'(commit_RegWrite), 64'd0);
    step();
    chk("t5_count_zero", 64'(count), 64'd0);

    // Test 6: flush with done head suppresses commit and clears everything
    do_reset();
    for (int i = 0; i < 4; i++) alloc_one(1'b1, 5'(1 + i), 3'(i));
    wb_valid = 1'b1; wb_tag = 3'd0; wb_data = 32'h6666_0000;
    @(posedge clk);
    #1;
    wb_valid = 1'b0; flush = 1'b1;
    #1 chk("t6_cv_in_flush", 64'(commit_valid), 64'd0);
    chk("t6_rw_in_flush", 64'(commit_RegWrite), 64'd0);
    chk("t6_count_in_flush", 64'(count), 64'd4);
    chk("t6_ready_in_flush", 64'(alloc_ready), 64'd1);
    step();
    flush = 1'b0;
    chk("t6_empty", 64'(empty), 64'd1);
    chk("t6_alloc_tag", 64'(alloc_tag), 64'd0);
    wb_one(3'd1, 32'h6666_0001);
    chk("t6_late_wb_count", 64'(count), 64'd0);
    sb_q.push_back('{tag: 3'd0, rd: 5'd9, data: 32'h6666_0009, rw: 1'b1});
    alloc_one(1'b1, 5'd9, 3'd0);
    chk("t6_new_not_done", 64'(commit_valid), 64'd0);
    wb_one(3'd0, 32'h6666_0009);
    step();
    chk("t6_final_empty", 64'(empty), 64'd1);

    repeat (3) step();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
